// File: rtl/datapath_pkg.sv
// Shared types and helpers for the parametrised register/accumulator datapath.
//   op_e        : 3-bit instruction opcode.
//   state_e     : sequencer state (idle / executing).
//   idx_width   : width of a register/input index for a given register count.
//   instr_width : total instruction word width, {op, dst, src_is_m, src_idx}.
package datapath_pkg;

  typedef enum logic [2:0] {
    OpNop = 3'b000,
    OpMov = 3'b001,
    OpAdc = 3'b010,
    OpSbc = 3'b011,
    OpAnd = 3'b100,
    OpOr  = 3'b101,
    OpXor = 3'b110,
    OpClr = 3'b111
  } op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StExec = 1'b1
  } state_e;

  // Index NREG addresses the accumulator, so NREG+1 codes are needed.
  function automatic int unsigned idx_width(input int unsigned nreg);
    return (nreg == 0) ? 1 : $clog2(nreg + 1);
  endfunction

  function automatic int unsigned instr_width(input int unsigned nreg);
    return 3 + idx_width(nreg) + 1 + idx_width(nreg);
  endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the datapath.
// Ports:
//   a      : accumulator operand
//   b      : source operand
//   cin    : carry-in for ADC/SBC
//   op     : opcode
//   result : WIDTH-bit result (wraps on overflow)
//   cout   : carry-out of ADC/SBC; 1 on SBC means no borrow; 0 for other ops
// MOV passes b through and CLR yields zero so the writeback path is uniform.
module dp_alu
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    cout   = 1'b0;
    unique case (op)
      OpMov: result = b;
      OpAdc: begin
        sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OpSbc: begin
        // Two's-complement subtract: a + ~b + cin, carry set means no borrow.
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OpAnd:   result = a & b;
      OpOr:    result = a | b;
      OpXor:   result = a ^ b;
      OpClr:   result = '0;
      OpNop:   result = '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/datapath_seq.sv
// Parametrised register-file / accumulator datapath behind a valid/ready
// instruction handshake. One instruction is accepted in IDLE, executed for one
// cycle, written back at the end of that cycle, and acknowledged by a one-cycle
// done_o pulse in the following cycle (throughput: one instruction per 2 clocks).
//
// Ports:
//   clk           : rising-edge clock
//   clr_ni        : synchronous active-low reset
//   m_i           : NIN external operands of WIDTH bits
//   cin_i         : external carry-in, sampled when an instruction is accepted
//   instr_valid_i : instruction offered
//   instr_ready_o : block can accept an instruction (IDLE and not in reset)
//   instr_i       : {op[2:0], dst[IDXW-1:0], src_is_m, src_idx[IDXW-1:0]}
//   r_q           : NREG general registers
//   a_q           : accumulator (register index NREG)
//   c_q           : carry flag, written only by ADC/SBC
//   z_q           : zero flag, written by ADC/SBC/logic ops and MOV/CLR to A
//   done_o        : one-cycle pulse after each writeback (NOP included)
//
// Configuration macro DP_CARRY_CHAIN_EN: when defined, ADC/SBC take their
// carry-in from c_q (multi-word chaining) and cin_i is ignored. When undefined,
// the carry-in is cin_i captured on the accept edge and c_q is status only.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREG  = 3,
  parameter int unsigned NIN   = 3
) (
  input  logic                           clk,
  input  logic                           clr_ni,
  input  logic [NIN-1:0][WIDTH-1:0]      m_i,
  input  logic                           cin_i,
  input  logic                           instr_valid_i,
  output logic                           instr_ready_o,
  input  logic [instr_width(NREG)-1:0]   instr_i,
  output logic [NREG-1:0][WIDTH-1:0]     r_q,
  output logic [WIDTH-1:0]               a_q,
  output logic                           c_q,
  output logic                           z_q,
  output logic                           done_o
);

  localparam int unsigned IDXW = idx_width(NREG);
  localparam int unsigned IW   = instr_width(NREG);

  // Instruction fields as offered on the bus.
  op_e             in_op;
  logic [IDXW-1:0] in_dst;
  logic            in_src_is_m;
  logic [IDXW-1:0] in_src_idx;

  assign in_src_idx  = instr_i[IDXW-1:0];
  assign in_src_is_m = instr_i[IDXW];
  assign in_dst      = instr_i[2*IDXW:IDXW+1];
  assign in_op       = op_e'(instr_i[IW-1 -: 3]);

  state_e state_q, state_d;
  logic   accept;
  logic   wb_en;
  logic   done_q;

  // Instruction context captured on the accept edge.
  op_e             op_q;
  logic [IDXW-1:0] dst_q;
  logic [WIDTH-1:0] opnd_q;
`ifndef DP_CARRY_CHAIN_EN
  logic            cin_q;
`endif

  logic [WIDTH-1:0]           opnd;
  logic                       alu_cin;
  logic [WIDTH-1:0]           alu_res;
  logic                       alu_cout;
  logic [NREG-1:0][WIDTH-1:0] r_d;
  logic [WIDTH-1:0]           a_d;
  logic                       c_d;
  logic                       z_d;

  assign accept = instr_valid_i & instr_ready_o;
  assign done_o = done_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. Ready is masked by reset so nothing is accepted on a reset edge.
  always_comb begin
    instr_ready_o = 1'b0;
    wb_en         = 1'b0;
    unique case (state_q)
      StIdle:  instr_ready_o = clr_ni;
      StExec:  wb_en = 1'b1;
      default: begin
        instr_ready_o = 1'b0;
        wb_en         = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand select: M[idx] (0 beyond NIN), R[idx], A at idx==NREG, else 0.
  // Indices are compared at 32 bits so out-of-range codes never alias.
  // ---------------------------------------------------------------------------
  always_comb begin
    opnd = '0;
    if (in_src_is_m) begin
      for (int unsigned i = 0; i < NIN; i++) begin
        if (32'(in_src_idx) == i) opnd = m_i[i];
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (32'(in_src_idx) == i) opnd = r_q[i];
      end
      if (32'(in_src_idx) == NREG) opnd = a_q;
    end
  end

`ifdef DP_CARRY_CHAIN_EN
  assign alu_cin = c_q;
`else
  assign alu_cin = cin_q;
`endif

  dp_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (a_q),
    .b      (opnd_q),
    .cin    (alu_cin),
    .op     (op_q),
    .result (alu_res),
    .cout   (alu_cout)
  );

  // ---------------------------------------------------------------------------
  // Writeback next-state. ADC/SBC/logic ops always target A regardless of dst.
  // dst beyond NREG writes nothing; done_o still pulses.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_d = r_q;
    a_d = a_q;
    c_d = c_q;
    z_d = z_q;
    if (wb_en) begin
      unique case (op_q)
        OpMov, OpClr: begin
          if (32'(dst_q) == NREG) begin
            a_d = alu_res;
            z_d = (alu_res == '0);
          end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
              if (32'(dst_q) == i) r_d[i] = alu_res;
            end
          end
        end
        OpAdc, OpSbc: begin
          a_d = alu_res;
          c_d = alu_cout;
          z_d = (alu_res == '0);
        end
        OpAnd, OpOr, OpXor: begin
          a_d = alu_res;
          z_d = (alu_res == '0);
        end
        default: begin
          a_d = a_q;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath state and accept-edge capture. Reset during EXEC drops the
  // pending writeback because wb_en is ignored in the reset branch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_ni) begin
      r_q    <= '0;
      a_q    <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      done_q <= 1'b0;
      op_q   <= OpNop;
      dst_q  <= '0;
      opnd_q <= '0;
`ifndef DP_CARRY_CHAIN_EN
      cin_q  <= 1'b0;
`endif
    end else begin
      r_q    <= r_d;
      a_q    <= a_d;
      c_q    <= c_d;
      z_q    <= z_d;
      done_q <= wb_en;
      if (accept) begin
        op_q   <= in_op;
        dst_q  <= in_dst;
        opnd_q <= opnd;
`ifndef DP_CARRY_CHAIN_EN
        cin_q  <= cin_i;
`endif
      end
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq (WIDTH=4, NREG=3, NIN=3, M0=3 M1=A M2=0).
// A reference model computes the architectural state after each accepted
// instruction; that snapshot is queued and compared when done_o pulses.
module tb_datapath_seq;

  localparam logic [2:0] OpNop = 3'd0;
  localparam logic [2:0] OpMov = 3'd1;
  localparam logic [2:0] OpAdc = 3'd2;
  localparam logic [2:0] OpSbc = 3'd3;
  localparam logic [2:0] OpAnd = 3'd4;
  localparam logic [2:0] OpOr  = 3'd5;
  localparam logic [2:0] OpXor = 3'd6;
  localparam logic [2:0] OpClr = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            clr_n;
  logic [2:0][3:0] m;
  logic            cin;
  logic            valid;
  logic            ready;
  logic [7:0]      instr;
  logic [2:0][3:0] r;
  logic [3:0]      a;
  logic            c;
  logic            z;
  logic            done;

  datapath_seq #(
    .WIDTH (4),
    .NREG  (3),
    .NIN   (3)
  ) dut (
    .clk           (clk),
    .clr_ni        (clr_n),
    .m_i           (m),
    .cin_i         (cin),
    .instr_valid_i (valid),
    .instr_ready_o (ready),
    .instr_i       (instr),
    .r_q           (r),
    .a_q           (a),
    .c_q           (c),
    .z_q           (z),
    .done_o        (done)
  );

  int errors = 0;
  int checks = 0;

  logic [17:0] sb [$];

  // Reference model state.
  logic [3:0] mr [3];
  logic [3:0] ma;
  logic       mc;
  logic       mz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [1:0] dst,
                                     input logic sm, input logic [1:0] si);
    return {op, dst, sm, si};
  endfunction

  function automatic logic [3:0] m_val(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'h3;
      2'd1:    return 4'hA;
      default: return 4'h0;  // M2 is 0; index 3 is out of range and reads 0
    endcase
  endfunction

  function automatic logic [17:0] dut_snap();
    return {r[0], r[1], r[2], a, c, z};
  endfunction

  function automatic logic [17:0] model_snap();
    return {mr[0], mr[1], mr[2], ma, mc, mz};
  endfunction

  task automatic model_reset();
    mr[0] = 4'h0;
    mr[1] = 4'h0;
    mr[2] = 4'h0;
    ma    = 4'h0;
    mc    = 1'b0;
    mz    = 1'b0;
  endtask

  task automatic model_write(input logic [1:0] dst, input logic [3:0] v);
    if (dst == 2'd3) begin
      ma = v;
      mz = (v == 4'h0);
    end else begin
      mr[dst] = v;
    end
  endtask

  task automatic model_apply(input logic [7:0] ins_w, input logic ci_ext);
    logic [2:0] op;
    logic [1:0] dst;
    logic       sm;
    logic [1:0] si;
    logic [3:0] s;
    logic [4:0] sum;
    logic       ci;
    op  = ins_w[7:5];
    dst = ins_w[4:3];
    sm  = ins_w[2];
    si  = ins_w[1:0];
    if (sm) s = m_val(si);
    else if (si == 2'd3) s = ma;
    else s = mr[si];
`ifdef DP_CARRY_CHAIN_EN
    ci = mc;
`else
    ci = ci_ext;
`endif
    case (op)
      OpMov: model_write(dst, s);
      OpAdc: begin
        sum = {1'b0, ma} + {1'b0, s} + {4'b0, ci};
        ma = sum[3:0]; mc = sum[4]; mz = (sum[3:0] == 4'h0);
      end
      OpSbc: begin
        sum = {1'b0, ma} + {1'b0, ~s} + {4'b0, ci};
        ma = sum[3:0]; mc = sum[4]; mz = (sum[3:0] == 4'h0);
      end
      OpAnd: begin ma = ma & s; mz = (ma == 4'h0); end
      OpOr:  begin ma = ma | s; mz = (ma == 4'h0); end
      OpXor: begin ma = ma ^ s; mz = (ma == 4'h0); end
      OpClr: model_write(dst, 4'h0);
      default: ;
    endcase
  endtask

  // Reset for two edges, checking ready is held low while clr_n is low.
  task automatic do_reset();
    clr_n = 1'b0;
    valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready_low", 32'(ready), 32'd0);
    chk("rst_done_low", 32'(done), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_state", 32'(dut_snap()), 32'(model_snap()));
    chk("rst_ready_after", 32'(ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Offer one instruction, then scramble instr/cin while it executes and check
  // latency, single-cycle done pulse and the resulting state.
  task automatic run(input string tag, input logic [7:0] ins_w);
    int   lat;
    bit   got;
    logic cin_set;
    cin_set = cin;
    instr   = ins_w;
    valid   = 1'b1;
    got     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_accept"}, 32'(got), 32'd1);
    if (got) begin
      model_apply(ins_w, cin_set);
      sb.push_back(model_snap());
    end
    @(posedge clk); #1;
    valid = 1'b0;
    instr = 8'($urandom);
    cin   = 1'($urandom);
    lat   = 0;
    got   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_exec_ready"}, 32'(ready), 32'd0);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_done_lat"}, 32'(lat), 32'd2);
      if (sb.size() > 0) chk({tag, "_state"}, 32'(dut_snap()), 32'(sb.pop_front()));
    end
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(done), 32'd0);
    cin = cin_set;
    @(posedge clk); #1;
  endtask

  logic [7:0] prog [3];
  int         k;
  int         ndone;
  logic       exp_rdy;

  initial begin
    m     = {4'h0, 4'hA, 4'h3};
    cin   = 1'b1;
    valid = 1'b0;
    instr = 8'h00;
    clr_n = 1'b0;
    model_reset();

    do_reset();

    // Basic moves and a subtract: A = 3 - A with carry-in 1 -> 9, borrow.
    run("t1_mov_r0_m0", ins(OpMov, 2'd0, 1'b1, 2'd0));
    run("t1_mov_r1_m1", ins(OpMov, 2'd1, 1'b1, 2'd1));
    run("t1_mov_a_r0",  ins(OpMov, 2'd3, 1'b0, 2'd0));
    run("t1_sbc_r1",    ins(OpSbc, 2'd0, 1'b0, 2'd1));
    run("t1_mov_r2_a",  ins(OpMov, 2'd2, 1'b0, 2'd3));
`ifndef DP_CARRY_CHAIN_EN
    chk("t1_r2_const", 32'(r[2]), 32'h9);
    chk("t1_a_const",  32'(a), 32'h9);
    chk("t1_c_const",  32'(c), 32'd0);
    chk("t1_z_const",  32'(z), 32'd0);
`endif

    // Carry generation and an A - A result that sets both flags.
    run("t2_clr_a", ins(OpClr, 2'd3, 1'b0, 2'd0));
    cin = 1'b0;
    run("t2_sbc_m2", ins(OpSbc, 2'd0, 1'b1, 2'd2));
    cin = 1'b1;
    run("t2_adc_m0", ins(OpAdc, 2'd0, 1'b1, 2'd0));
    run("t2_sbc_a",  ins(OpSbc, 2'd0, 1'b0, 2'd3));
`ifndef DP_CARRY_CHAIN_EN
    chk("t2_a_const", 32'(a), 32'h0);
    chk("t2_c_const", 32'(c), 32'd1);
    chk("t2_z_const", 32'(z), 32'd1);
`endif

    // Logic ops and NOP.
    run("lg_mov_a_r1", ins(OpMov, 2'd3, 1'b0, 2'd1));
    run("lg_and_m0",   ins(OpAnd, 2'd0, 1'b1, 2'd0));
    run("lg_or_r0",    ins(OpOr,  2'd0, 1'b0, 2'd0));
    run("lg_xor_m1",   ins(OpXor, 2'd0, 1'b1, 2'd1));
    run("lg_nop",      ins(OpNop, 2'd2, 1'b1, 2'd1));

    // Back-to-back with valid held high: ready alternates, each instr runs once.
    prog[0] = ins(OpMov, 2'd0, 1'b1, 2'd1);
    prog[1] = ins(OpAdc, 2'd0, 1'b1, 2'd0);
    prog[2] = ins(OpXor, 2'd0, 1'b0, 2'd0);
    k       = 0;
    ndone   = 0;
    instr   = prog[0];
    valid   = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      exp_rdy = (cyc < 6) ? ((cyc % 2) == 0) : 1'b1;
      chk($sformatf("t3_ready_%0d", cyc), 32'(ready), 32'(exp_rdy));
      if (done) begin
        ndone++;
        if (sb.size() > 0) chk($sformatf("t3_state_%0d", cyc), 32'(dut_snap()), 32'(sb.pop_front()));
      end
      if (valid && ready) begin
        model_apply(instr, cin);
        sb.push_back(model_snap());
        k++;
      end
      @(posedge clk); #1;
      if (k < 3) instr = prog[k];
      else valid = 1'b0;
    end
    chk("t3_done_count", 32'(ndone), 32'd3);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Valid low in IDLE: instr noise must not change anything.
    for (int i = 0; i < 4; i++) begin
      instr = 8'($urandom);
      @(negedge clk);
      chk($sformatf("idle_done_%0d", i), 32'(done), 32'd0);
      chk($sformatf("idle_ready_%0d", i), 32'(ready), 32'd1);
      @(posedge clk); #1;
    end
    chk("idle_state", 32'(dut_snap()), 32'(model_snap()));

    // Out-of-range M index reads zero.
    run("t5_mov_r0_m3", ins(OpMov, 2'd0, 1'b1, 2'd3));
    chk("t5_r0_zero", 32'(r[0]), 32'h0);

    // Reset during EXEC of MOV R1,M1 aborts the writeback.
    do_reset();
    instr = ins(OpMov, 2'd1, 1'b1, 2'd1);
    valid = 1'b1;
    @(negedge clk);
    chk("t4_ready_offer", 32'(ready), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    clr_n = 1'b0;
    @(negedge clk);
    chk("t4_ready_in_reset", 32'(ready), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("t4_no_done", 32'(ndone), 32'd0);
    chk("t4_r1_zero", 32'(r[1]), 32'h0);
    chk("t4_state", 32'(dut_snap()), 32'(model_snap()));
    @(negedge clk);
    chk("t4_ready_after", 32'(ready), 32'd1);
    @(posedge clk); #1;

    // Carry source: set c, clear A (CLR keeps c), then ADC M2 with cin_i=0.
    cin = 1'b1;
    run("t6_mov_a_m1", ins(OpMov, 2'd3, 1'b1, 2'd1));
    run("t6_adc_m1",   ins(OpAdc, 2'd0, 1'b1, 2'd1));
    run("t6_clr_a",    ins(OpClr, 2'd3, 1'b0, 2'd0));
    chk("t6_c_held", 32'(c), 32'd1);
    cin = 1'b0;
    run("t6_adc_m2",   ins(OpAdc, 2'd0, 1'b1, 2'd2));
`ifdef DP_CARRY_CHAIN_EN
    chk("t6_a_chain", 32'(a), 32'h1);
`else
    chk("t6_a_cin", 32'(a), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
